// File: rtl/io_port_fifo.sv
// Memory-mapped I/O port: CPU write FIFO drained over valid/ready, single-word input holding register, status word.
// Optional sticky overflow flag in status bit 12 is enabled by defining IO_OVERFLOW_FLAG_EN.
module io_port_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_rd,
  input  logic              cpu_rd_sel,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [DATA_W-1:0] ext_out_data,
  output logic              ext_out_valid,
  input  logic              ext_out_ready,
  input  logic [DATA_W-1:0] ext_in_data,
  input  logic              ext_in_valid,
  output logic              ext_in_ready,
  output logic              out_full,
  output logic              in_avail
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              in_avail_q, in_avail_d;
  logic              push_s, pop_s, load_s, consume_s, full_s, ovf_s;
  logic [3:0]        cnt4_s;
  logic [DATA_W-1:0] status_s;

  // Handshake decode; a status read never consumes the holding register.
  always_comb begin
    full_s    = (count_q == CNT_FULL);
    pop_s     = (count_q != {(AW+1){1'b0}}) && ext_out_ready;
    push_s    = cpu_wr && (!full_s || pop_s);
    consume_s = cpu_rd && !cpu_rd_sel && in_avail_q;
    load_s    = ext_in_valid && (!in_avail_q || consume_s);
  end

  // Next-state for FIFO pointers/count and the input holding register.
  always_comb begin
    wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (load_s) begin
      hold_d     = ext_in_data;
      in_avail_d = 1'b1;
    end else if (consume_s) begin
      hold_d     = hold_q;
      in_avail_d = 1'b0;
    end else begin
      hold_d     = hold_q;
      in_avail_d = in_avail_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      hold_q     <= {DATA_W{1'b0}};
      in_avail_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      in_avail_q <= in_avail_d;
    end
  end

  // FIFO storage; contents are don't-care until a pointer references them.
  always_ff @(posedge clock) begin
    if (reset && push_s) begin
      mem_q[wr_ptr_q] <= cpu_wr_data;
    end
  end

`ifdef IO_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d, drop_s;

  // Sticky drop flag; a drop in the same cycle as a status read wins over the clear.
  always_comb begin
    drop_s = cpu_wr && full_s && !pop_s;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (cpu_rd && cpu_rd_sel) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_s = ovf_q;
`else
  assign ovf_s = 1'b0;
`endif

  // Status word and CPU read mux.
  always_comb begin
    cnt4_s   = 4'(count_q);
    status_s = {DATA_W{1'b0}};
    status_s[DATA_W-1 -: 4] = {in_avail_q, full_s, (count_q != {(AW+1){1'b0}}), ovf_s};
    status_s[3:0] = cnt4_s;
    if (cpu_rd_sel) begin
      cpu_rd_data = status_s;
    end else if (in_avail_q) begin
      cpu_rd_data = hold_q;
    end else begin
      cpu_rd_data = {DATA_W{1'b0}};
    end
  end

  assign ext_out_data  = mem_q[rd_ptr_q];
  assign ext_out_valid = (count_q != {(AW+1){1'b0}});
  assign out_full      = full_s;
  assign in_avail      = in_avail_q;
  assign ext_in_ready  = !in_avail_q || consume_s;

endmodule

// File: tb/tb_io_port_fifo.sv
// Directed self-checking bench for io_port_fifo; overflow expectations follow IO_OVERFLOW_FLAG_EN.
module tb_io_port_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_wr;
  logic [15:0] cpu_wr_data;
  logic        cpu_rd;
  logic        cpu_rd_sel;
  logic [15:0] cpu_rd_data;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic        out_full;
  logic        in_avail;

  int tests = 0;
  int fails = 0;

  io_port_fifo #(.DATA_W(16), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_wr(cpu_wr), .cpu_wr_data(cpu_wr_data),
    .cpu_rd(cpu_rd), .cpu_rd_sel(cpu_rd_sel), .cpu_rd_data(cpu_rd_data),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .out_full(out_full), .in_avail(in_avail)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    cpu_wr = 1'b1; cpu_wr_data = w;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    cpu_rd_sel = 1'b0; #1;
    tests++; if (ext_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ext_out_valid); end
    tests++; if (ext_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", ext_in_ready); end
    tests++; if (in_avail !== 1'b0) begin fails++; $display("FAIL reset_in_avail got %b exp 0", in_avail); end
    tests++; if (out_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", out_full); end
    tests++; if (cpu_rd_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h exp 0000", cpu_rd_data); end
    cpu_rd_sel = 1'b1; #1;
    tests++; if (cpu_rd_data !== 16'h0000) begin fails++; $display("FAIL reset_status got %h exp 0000", cpu_rd_data); end
    cpu_rd_sel = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [15:0] w [4];
    w = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    ext_out_ready = 1'b0;
    write_word(w[0]);
    tests++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h0011) begin fails++; $display("FAIL first_write got v=%b d=%h exp v=1 d=0011", ext_out_valid, ext_out_data); end
    for (int i = 1; i < 4; i++) write_word(w[i]);
    cpu_rd_sel = 1'b1; #1;
    tests++; if (out_full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", out_full); end
    tests++; if (cpu_rd_data !== 16'h6004) begin fails++; $display("FAIL fill_status got %h exp 6004", cpu_rd_data); end
    write_word(16'h0055);
    tests++; if (cpu_rd_data[3:0] !== 4'h4 || ext_out_data !== 16'h0011) begin fails++; $display("FAIL drop_state got cnt=%h head=%h exp cnt=4 head=0011", cpu_rd_data[3:0], ext_out_data); end
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
    cpu_rd_sel = 1'b0;
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (ext_out_valid !== 1'b1 || ext_out_data !== w[i]) begin fails++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, ext_out_valid, ext_out_data, w[i]); end
      tick();
    end
    tests++; if (ext_out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b exp 0", ext_out_valid); end
    ext_out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] w [4];
    w = '{16'h0002, 16'h0003, 16'h0004, 16'h0099};
    ext_out_ready = 1'b0;
    write_word(16'h0001);
    for (int i = 0; i < 3; i++) write_word(w[i]);
    ext_out_ready = 1'b1; cpu_wr = 1'b1; cpu_wr_data = 16'h0099;
    tick();
    cpu_wr = 1'b0; ext_out_ready = 1'b0; cpu_rd_sel = 1'b1; #1;
    tests++; if (cpu_rd_data !== 16'h6004) begin fails++; $display("FAIL pushpop_status got %h exp 6004", cpu_rd_data); end
    cpu_rd_sel = 1'b0;
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (ext_out_valid !== 1'b1 || ext_out_data !== w[i]) begin fails++; $display("FAIL pushpop_drain_%0d got v=%b d=%h exp v=1 d=%h", i, ext_out_valid, ext_out_data, w[i]); end
      tick();
    end
    tests++; if (ext_out_valid !== 1'b0) begin fails++; $display("FAIL pushpop_empty got %b exp 0", ext_out_valid); end
    ext_out_ready = 1'b0;
  endtask

  task automatic test_input();
    ext_in_valid = 1'b1; ext_in_data = 16'hBEEF; cpu_rd_sel = 1'b0;
    tick();
    ext_in_data = 16'h1234;
    #1;
    tests++; if (in_avail !== 1'b1 || cpu_rd_data !== 16'hBEEF || ext_in_ready !== 1'b0) begin fails++; $display("FAIL in_load got a=%b d=%h r=%b exp a=1 d=beef r=0", in_avail, cpu_rd_data, ext_in_ready); end
    tick();
    tests++; if (cpu_rd_data !== 16'hBEEF) begin fails++; $display("FAIL in_holdoff got %h exp beef", cpu_rd_data); end
    ext_in_valid = 1'b0; cpu_rd_sel = 1'b1; #1;
    tests++; if (cpu_rd_data !== 16'h8000) begin fails++; $display("FAIL in_status got %h exp 8000", cpu_rd_data); end
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0; cpu_rd_sel = 1'b0; #1;
    tests++; if (in_avail !== 1'b1 || cpu_rd_data !== 16'hBEEF) begin fails++; $display("FAIL status_no_consume got a=%b d=%h exp a=1 d=beef", in_avail, cpu_rd_data); end
    cpu_rd = 1'b1; ext_in_valid = 1'b1; ext_in_data = 16'hCAFE; #1;
    tests++; if (ext_in_ready !== 1'b1) begin fails++; $display("FAIL refill_ready got %b exp 1", ext_in_ready); end
    tick();
    cpu_rd = 1'b0; ext_in_valid = 1'b0; #1;
    tests++; if (in_avail !== 1'b1 || cpu_rd_data !== 16'hCAFE) begin fails++; $display("FAIL refill got a=%b d=%h exp a=1 d=cafe", in_avail, cpu_rd_data); end
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0; #1;
    tests++; if (in_avail !== 1'b0 || cpu_rd_data !== 16'h0000 || ext_in_ready !== 1'b1) begin fails++; $display("FAIL consume got a=%b d=%h r=%b exp a=0 d=0000 r=1", in_avail, cpu_rd_data, ext_in_ready); end
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0; #1;
    tests++; if (in_avail !== 1'b0) begin fails++; $display("FAIL empty_read got %b exp 0", in_avail); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_set;
`ifdef IO_OVERFLOW_FLAG_EN
    exp_set = 16'h7004;
`else
    exp_set = 16'h6004;
`endif
    ext_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(16'h0100 + 16'(i));
    write_word(16'h01FF);
    cpu_rd_sel = 1'b1; #1;
    tests++; if (cpu_rd_data !== exp_set) begin fails++; $display("FAIL ovf_set got %h exp %h", cpu_rd_data, exp_set); end
    cpu_rd = 1'b1; tick(); cpu_rd = 1'b0; #1;
    tests++; if (cpu_rd_data !== 16'h6004) begin fails++; $display("FAIL ovf_clear got %h exp 6004", cpu_rd_data); end
    cpu_rd_sel = 1'b0;
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ext_out_ready = 1'b0;
    tests++; if (ext_out_valid !== 1'b0) begin fails++; $display("FAIL ovf_drain got %b exp 0", ext_out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    ext_out_ready = 1'b0;
    write_word(16'h00A1); write_word(16'h00A2); write_word(16'h00A3);
    ext_out_ready = 1'b1;
    tick();
    tests++; if (ext_out_data !== 16'h00A2) begin fails++; $display("FAIL middrain_head got %h exp 00a2", ext_out_data); end
    reset = 1'b0; cpu_wr = 1'b1; cpu_wr_data = 16'h0077;
    tick();
    reset = 1'b1; cpu_wr = 1'b0; cpu_rd_sel = 1'b1; #1;
    tests++; if (ext_out_valid !== 1'b0 || out_full !== 1'b0) begin fails++; $display("FAIL middrain_reset got v=%b f=%b exp v=0 f=0", ext_out_valid, out_full); end
    tests++; if (cpu_rd_data !== 16'h0000) begin fails++; $display("FAIL middrain_status got %h exp 0000", cpu_rd_data); end
    tick(); tick();
    tests++; if (ext_out_valid !== 1'b0) begin fails++; $display("FAIL middrain_idle got %b exp 0", ext_out_valid); end
    ext_out_ready = 1'b0;
    write_word(16'h0088);
    tests++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h0088) begin fails++; $display("FAIL postreset_write got v=%b d=%h exp v=1 d=0088", ext_out_valid, ext_out_data); end
    cpu_rd_sel = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cpu_wr = 1'b0; cpu_wr_data = 16'h0000; cpu_rd = 1'b0; cpu_rd_sel = 1'b0;
    ext_out_ready = 1'b0; ext_in_data = 16'h0000; ext_in_valid = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_input();
    test_overflow();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_port_fifo.md
# io_port_fifo

Memory-mapped I/O port controller between the PC/SP/memory block's address-255 I/O path and the board-level peripherals (switches/display/host link). CPU-side writes are captured in a small output FIFO and drained to the peripheral over a valid/ready handshake. Peripheral input words are latched into a single holding register that the CPU reads. A status word lets software poll occupancy without losing data.

## Interface
Parameters:
- DATA_W, 16, word width of the CPU and peripheral data paths
- DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_wr  in  1  one-cycle strobe; the CPU writes to address 255 (MemWrite with ze_imm == 255)
- cpu_wr_data  in  DATA_W  word to send (MaryData)
- cpu_rd  in  1  one-cycle strobe; the CPU consumes the input word
- cpu_rd_sel  in  1  0 = data word, 1 = status word on cpu_rd_data
- cpu_rd_data  out  DATA_W  combinational read data; feeds io_in of the memory block
- ext_out_data  out  DATA_W  FIFO head word
- ext_out_valid  out  1  FIFO not empty
- ext_out_ready  in  1  peripheral accepts the head word this cycle
- ext_in_data  in  DATA_W  peripheral input word
- ext_in_valid  in  1  peripheral offers a word
- ext_in_ready  out  1  holding register empty
- out_full  out  1  FIFO count == DEPTH
- in_avail  out  1  holding register holds an unread word

## Operation
- Output FIFO: circular buffer with write/read pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
  - Push when cpu_wr && (!out_full || pop_this_cycle).
  - Pop when ext_out_valid && ext_out_ready.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the push is accepted because a slot frees in the same cycle.
  - When empty, only the push takes effect, since a pop requires valid and valid is low.
- A cpu_wr while full with no pop is dropped. FIFO contents, pointers and count are unchanged.
- The input holding register has three-state behaviour: EMPTY, FULL, and FULL with a simultaneous refill.
  - Load when ext_in_valid && ext_in_ready. in_avail rises on the next cycle.
  - cpu_rd while in_avail clears in_avail next cycle.
  - cpu_rd while !in_avail has no effect.
  - ext_in_ready = !in_avail || cpu_rd. A read and a new load in the same cycle leave in_avail = 1 with the new word.
- Data word (cpu_rd_sel = 0):
  - cpu_rd_data = holding register when in_avail.
  - Otherwise cpu_rd_data = 16'h0000.
- Status word (cpu_rd_sel = 1) is {in_avail, out_full, ext_out_valid, overflow, 8'h00, count zero-extended to 4 bits}.
  - The overflow bit is 0 when IO_OVERFLOW_FLAG_EN is undefined.
  - cpu_rd with cpu_rd_sel = 1 does not consume the holding register.

## Timing
- Reset values (reset low at an edge):
  - pointers = 0, count = 0
  - ext_out_valid = 0, out_full = 0
  - in_avail = 0, ext_in_ready = 1
  - holding register = 0, overflow = 0
  - cpu_rd_data = 0
- Reset has priority over every simultaneous strobe. A cpu_wr during reset is lost.
- Write latency: a cpu_wr at edge N makes ext_out_valid = 1 and ext_out_data = the word after edge N. There is no same-cycle bypass.
- ext_out_data must remain stable while ext_out_valid && !ext_out_ready.
- Input latency: a word accepted at edge N is readable from cycle N+1.
- All outputs except cpu_rd_data and ext_in_ready are registered or decoded from registered state only.

## Configuration
- Macro: IO_OVERFLOW_FLAG_EN.
- When defined:
  - A sticky overflow register sets when a cpu_wr is dropped.
  - It is cleared only by reset or by a status read (cpu_rd && cpu_rd_sel).
  - Clear takes priority unless a drop occurs in the same cycle, in which case it stays set.
  - The overflow register is reported in status bit 12.
- When undefined: no overflow register, status bit 12 is tied to 0, and drops are silent.

## Test plan
- Reset then idle:
  - Expected: ext_out_valid = 0, ext_in_ready = 1, in_avail = 0.
  - Expected: cpu_rd_data = 16'h0000 with sel = 0; status = 16'h0000.
- Four cpu_wr (16'h0011, 16'h0022, 16'h0033, 16'h0044) with ext_out_ready = 0:
  - Expected: out_full = 1, status = 16'h6004.
  - Then 16'h0055 is dropped.
  - With ext_out_ready = 1, the drained sequence is exactly 11, 22, 33, 44.
- FIFO full, cpu_wr 16'h0099 in the same cycle as an ext pop:
  - Expected: count stays 4 and 16'h0099 is drained last.
- ext_in_valid with 16'hBEEF:
  - Expected: in_avail = 1 next cycle, cpu_rd_data = 16'hBEEF, ext_in_ready = 0.
  - A second word is held off until cpu_rd.
  - cpu_rd plus ext_in_valid 16'hCAFE in the same cycle: in_avail stays 1, data = 16'hCAFE.
- With IO_OVERFLOW_FLAG_EN, fill the FIFO and drop one write:
  - Expected: status bit 12 = 1.
  - A status read clears the bit; the next status read shows 0.
- Reset asserted mid-drain with 3 entries queued:
  - Expected: next cycle ext_out_valid = 0, count = 0, and the old data never appears.
